dnn_img_loader: RTL

//  Write-side front end of the inference engine's shared activation memory. Accepts one MNIST

---
 rtl/dnn_img_loader_if.sv | 36 +++
 rtl/dnn_img_loader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dnn_img_loader_if.sv
// dnn_img_loader_if: bundles the pixel stream, memory write port,
// engine control and result handshake around the image loader.
// Ports: none; master = loader side, slave = environment side.
interface dnn_img_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) ();
    logic                           s_valid;
    logic                           s_ready;
    logic [DATA_WIDTH-1:0]          s_data;
    logic                           s_last;
    logic                           wr_en;
    logic [ADDR_WIDTH-1:0]          wr_addr;
    logic [DATA_WIDTH-1:0]          wr_data;
    logic                           eng_reset;
    logic                           eng_start;
    logic                           eng_done;
    logic [9:0][DATA_WIDTH-1:0]     eng_out;
    logic                           res_valid;
    logic                           res_ready;
    logic [3:0]                     res_class;
    logic [DATA_WIDTH-1:0]          res_score;
    logic                           err_len;

    modport master (
        input  s_valid, s_data, s_last, eng_done, eng_out, res_ready,
        output s_ready, wr_en, wr_addr, wr_data, eng_reset, eng_start,
        output res_valid, res_class, res_score, err_len
    );

    modport slave (
        output s_valid, s_data, s_last, eng_done, eng_out, res_ready,
        input  s_ready, wr_en, wr_addr, wr_data, eng_reset, eng_start,
        input  res_valid, res_class, res_score, err_len
    );
endinterface

// File: rtl/dnn_img_loader.sv
// dnn_img_loader: writes one image into activation memory, clears and
// starts the engine, waits for done, then returns argmax of 10 outputs.
// Ports: clk, rst (async active-low), bus (dnn_img_loader_if.master).
module dnn_img_loader #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int ADDR_BASE_A = 0,
    parameter int NUM_PIXELS  = 784
) (
    input  logic             clk,
    input  logic             rst,
    dnn_img_loader_if.master bus
);
    localparam int CW = $clog2(NUM_PIXELS);

    typedef enum logic [2:0] {
        S_LOAD,
        S_CLR,
        S_START,
        S_WAIT,
        S_ARGMAX,
        S_RESULT
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            ai_q, ai_d;
    logic                  s_ready_q, s_ready_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] cap_q [10];
    logic [DATA_WIDTH-1:0] cap_d [10];
    logic [DATA_WIDTH-1:0] best_q, best_d;
    logic [3:0]            idx_q, idx_d;
    logic [3:0]            res_class_q, res_class_d;
    logic [DATA_WIDTH-1:0] res_score_q, res_score_d;
    logic                  beat;
    logic                  last_pix;

    assign beat     = bus.s_valid & s_ready_q;
    assign last_pix = (cnt_q == CW'(NUM_PIXELS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ai_d        = ai_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        err_d       = err_q;
        cap_d       = cap_q;
        best_d      = best_q;
        idx_d       = idx_q;
        res_class_d = res_class_q;
        res_score_d = res_score_q;
        unique case (state_q)
            S_LOAD: begin
                if (beat) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_WIDTH'(ADDR_BASE_A)
                              + ADDR_WIDTH'(cnt_q);
                    wr_data_d = bus.s_data;
                    if (last_pix) begin
                        cnt_d   = '0;
                        state_d = S_CLR;
                        if (!bus.s_last) err_d = 1'b1;
                    end else if (bus.s_last) begin
                        // Short frame: keep the write, drop the frame.
                        cnt_d = '0;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_CLR:   state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.eng_done) begin
                    for (int k = 0; k < 10; k++) cap_d[k] = bus.eng_out[k];
                    ai_d    = '0;
                    state_d = S_ARGMAX;
                end
            end
            S_ARGMAX: begin
                // ai==0 seeds with out[0]; ai=1..9 each do one compare.
                if (ai_q == 4'd0) begin
                    best_d = cap_q[0];
                    idx_d  = 4'd0;
                end else if ($signed(cap_q[ai_q]) > $signed(best_q)) begin
                    best_d = cap_q[ai_q];
                    idx_d  = ai_q;
                end
                ai_d = ai_q + 4'd1;
                if (ai_q == 4'd9) begin
                    res_score_d = best_d;
                    res_class_d = idx_d;
                    state_d     = S_RESULT;
                end
            end
            S_RESULT: begin
                if (bus.res_ready) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
        s_ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            ai_q        <= '0;
            s_ready_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_q       <= 1'b0;
            best_q      <= '0;
            idx_q       <= '0;
            res_class_q <= '0;
            res_score_q <= '0;
            for (int k = 0; k < 10; k++) cap_q[k] <= '0;
        end else begin
            cnt_q       <= cnt_d;
            ai_q        <= ai_d;
            s_ready_q   <= s_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            err_q       <= err_d;
            best_q      <= best_d;
            idx_q       <= idx_d;
            res_class_q <= res_class_d;
            res_score_q <= res_score_d;
            for (int k = 0; k < 10; k++) cap_q[k] <= cap_d[k];
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.eng_reset = (state_q == S_CLR);
    assign bus.eng_start = (state_q == S_START);
    assign bus.res_valid = (state_q == S_RESULT);
    assign bus.res_class = res_class_q;
    assign bus.res_score = res_score_q;
    assign bus.err_len   = err_q;
endmodule
